// File: rtl/div_if.sv
// Handshake and data bundle between the EX stage and the divider.
// master: EX side (drives operands, start and annul; receives the result).
// slave:  divider side.
// Signals:
//   signed_div_i  1 = DIV (signed), 0 = DIVU
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       level request, held until ready_o is seen
//   annul_i       abort the operation in flight
//   result_o      {remainder (HI), quotient (LO)}
//   ready_o       result_o is valid
//   busy_o        divider is not idle
interface div_if #(
  parameter int unsigned DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
  logic                  busy_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU. One quotient bit per cycle,
// MSB first. Result is {remainder, quotient}, matching the {HI, LO} pair.
// Ports:
//   clk  clock, rising edge
//   rst  synchronous reset, active-high
//   bus  div_if slave modport (operands, start/annul in; result/ready/busy out)
module div_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input logic  clk,
  input logic  rst,
  div_if.slave bus
);

  typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

  state_e              state, state_next;
  logic [CNT_W-1:0]    count, count_next;
  // Dividend magnitude; shifts left so its MSB feeds the partial remainder.
  logic [DATA_W-1:0]   dividend, dividend_next;
  logic [DATA_W-1:0]   divisor, divisor_next;
  logic [DATA_W-1:0]   rem, rem_next;
  logic [DATA_W-1:0]   quot, quot_next;
  logic                sign_mode, sign_mode_next;
  logic                neg_a, neg_a_next;
  logic                neg_b, neg_b_next;
  logic [2*DATA_W-1:0] result, result_next;
  logic                ready, ready_next;

  logic [DATA_W:0]     rem_shift;
  logic [DATA_W:0]     trial;
  logic [DATA_W-1:0]   rem_step, quot_step;
  logic [DATA_W-1:0]   rem_fix, quot_fix;
  logic [DATA_W-1:0]   mag_a, mag_b;
  logic                last_iter;

  // One restoring step at DATA_W+1 bits; a set MSB means the trial went negative.
  assign rem_shift = {rem, dividend[DATA_W-1]};
  assign trial     = rem_shift - {1'b0, divisor};

  always_comb begin
    rem_step  = trial[DATA_W-1:0];
    quot_step = {quot[DATA_W-2:0], 1'b1};
    if (trial[DATA_W]) begin
      rem_step  = rem_shift[DATA_W-1:0];
      quot_step = {quot[DATA_W-2:0], 1'b0};
    end
  end

  // Sign fix-up applied to the final step; results wrap, so the most
  // negative dividend over -1 yields itself.
  assign quot_fix  = (sign_mode && (neg_a ^ neg_b)) ? -quot_step : quot_step;
  assign rem_fix   = (sign_mode && neg_a) ? -rem_step : rem_step;

  assign mag_a     = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i
                                                                    : bus.opdata1_i;
  assign mag_b     = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i
                                                                    : bus.opdata2_i;
  assign last_iter = (count == CNT_W'(DATA_W - 1));

  always_comb begin
    state_next     = state;
    count_next     = count;
    dividend_next  = dividend;
    divisor_next   = divisor;
    rem_next       = rem;
    quot_next      = quot;
    sign_mode_next = sign_mode;
    neg_a_next     = neg_a;
    neg_b_next     = neg_b;
    result_next    = result;
    ready_next     = ready;

    unique case (state)
      StFree: begin
        result_next = '0;
        ready_next  = 1'b0;
        if (bus.start_i && !bus.annul_i) begin
          sign_mode_next = bus.signed_div_i;
          neg_a_next     = bus.opdata1_i[DATA_W-1];
          neg_b_next     = bus.opdata2_i[DATA_W-1];
          if (bus.opdata2_i == '0) begin
            state_next = StByZero;
          end else begin
            state_next    = StOn;
            count_next    = '0;
            dividend_next = mag_a;
            divisor_next  = mag_b;
            rem_next      = '0;
            quot_next     = '0;
          end
        end
      end

      StByZero: begin
        if (bus.annul_i) begin
          state_next = StFree;
          count_next = '0;
        end else begin
          state_next = StEnd;
          rem_next   = '0;
          quot_next  = '0;
        end
      end

      StOn: begin
        if (bus.annul_i) begin
          state_next  = StFree;
          count_next  = '0;
          result_next = '0;
          ready_next  = 1'b0;
        end else begin
          count_next    = count + CNT_W'(1);
          dividend_next = {dividend[DATA_W-2:0], 1'b0};
          if (last_iter) begin
            state_next = StEnd;
            rem_next   = rem_fix;
            quot_next  = quot_fix;
          end else begin
            rem_next   = rem_step;
            quot_next  = quot_step;
          end
        end
      end

      StEnd: begin
        if (bus.annul_i || !bus.start_i) begin
          state_next  = StFree;
          count_next  = '0;
          result_next = '0;
          ready_next  = 1'b0;
        end else begin
          result_next = {rem, quot};
          ready_next  = 1'b1;
        end
      end

      default: state_next = StFree;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StFree;
      count     <= '0;
      dividend  <= '0;
      divisor   <= '0;
      rem       <= '0;
      quot      <= '0;
      sign_mode <= 1'b0;
      neg_a     <= 1'b0;
      neg_b     <= 1'b0;
      result    <= '0;
      ready     <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      dividend  <= dividend_next;
      divisor   <= divisor_next;
      rem       <= rem_next;
      quot      <= quot_next;
      sign_mode <= sign_mode_next;
      neg_a     <= neg_a_next;
      neg_b     <= neg_b_next;
      result    <= result_next;
      ready     <= ready_next;
    end
  end

  assign bus.result_o = result;
  assign bus.ready_o  = ready;
  assign bus.busy_o   = (state != StFree);

endmodule
